// File: rtl/multi_issue_pipe_reg.sv
// N-lane pipeline register with valid/ready handshake, optional two-entry skid
// buffer, global flush and per-lane kill of the presented bundle.
module multi_issue_pipe_reg #(
    parameter int unsigned LANES = 2,
    parameter int unsigned DW    = 128,
    parameter int unsigned SKID  = 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  flush,
    input  logic [LANES-1:0]      in_valid,
    input  logic [LANES*DW-1:0]   in_data,
    output logic                  in_ready,
    output logic [LANES-1:0]      out_valid,
    output logic [LANES*DW-1:0]   out_data,
    input  logic                  out_ready,
    input  logic [LANES-1:0]      kill_mask,
    output logic [1:0]            occupancy
);

    localparam int unsigned BW = LANES * DW;

    logic [LANES-1:0] m_valid, m_valid_n, s_valid, s_valid_n, kept_valid;
    logic [BW-1:0]    m_data, m_data_n, s_data, s_data_n, kept_data, in_data_z;
    logic             in_ready_q, m_full, s_full, m_hold, in_fire, out_fire;
    logic [1:0]       occ_q, occ_n;

    // Invalid lanes always carry zero data.
    function automatic logic [BW-1:0] zero_lanes(input logic [LANES-1:0] v,
                                                 input logic [BW-1:0]    d);
        logic [BW-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (v[i]) r[i*DW +: DW] = d[i*DW +: DW];
        end
        return r;
    endfunction

    // Next-state for main (M) and skid (S) registers.
    always_comb begin
        m_full     = |m_valid;
        s_full     = |s_valid;
        in_ready   = (SKID != 0) ? in_ready_q : (!m_full || out_ready);
        in_fire    = in_ready && (|in_valid) && !flush;
        out_fire   = out_ready && m_full;
        kept_valid = m_valid & ~kill_mask;
        kept_data  = zero_lanes(kept_valid, m_data);
        in_data_z  = zero_lanes(in_valid, in_data);
        m_hold     = !out_fire && (|kept_valid);

        m_valid_n  = '0;
        m_data_n   = '0;
        s_valid_n  = s_valid;
        s_data_n   = s_data;

        if (m_hold) begin
            m_valid_n = kept_valid;
            m_data_n  = kept_data;
        end

        if (SKID != 0) begin
            // in_ready_q is low whenever S is full, so S is free on any in_fire.
            if (m_hold) begin
                if (in_fire) begin
                    s_valid_n = in_valid;
                    s_data_n  = in_data_z;
                end
            end else if (s_full) begin
                m_valid_n = s_valid;
                m_data_n  = s_data;
                s_valid_n = '0;
                s_data_n  = '0;
            end else if (in_fire) begin
                m_valid_n = in_valid;
                m_data_n  = in_data_z;
            end
        end else if (in_fire) begin
            m_valid_n = in_valid;
            m_data_n  = in_data_z;
        end

        occ_n = 2'(|m_valid_n) + 2'(|s_valid_n);
    end

    // State registers; reset and flush clear everything.
    always_ff @(posedge clk) begin
        if (!resetn || flush) begin
            m_valid    <= '0;
            m_data     <= '0;
            s_valid    <= '0;
            s_data     <= '0;
            occ_q      <= 2'd0;
            in_ready_q <= 1'b1;
        end else begin
            m_valid    <= m_valid_n;
            m_data     <= m_data_n;
            s_valid    <= s_valid_n;
            s_data     <= s_data_n;
            occ_q      <= occ_n;
            in_ready_q <= ~(|s_valid_n);
        end
    end

    assign out_valid = m_valid;
    assign out_data  = m_data;
    assign occupancy = occ_q;

endmodule
